// File: rtl/latex_stream_pkg.sv
// Shared types and constants for the LaTeX transform byte-stream engine.
package latex_stream_pkg;

  typedef enum logic [1:0] {
    MODE_LHS     = 2'd0,
    MODE_RHS     = 2'd1,
    MODE_LHS_RHS = 2'd2,
    MODE_RHS_LHS = 2'd3
  } mode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PTR,
    S_PWAIT,
    S_SEG_INIT,
    S_FETCH,
    S_MWAIT,
    S_EMIT,
    S_SEP,
    S_TERM,
    S_FIN
  } state_e;

  localparam logic [7:0] ASCII_EQUALS  = 8'h3D;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

  // Pointer entry layout, MSB first: {lhs_base, lhs_len, rhs_base, rhs_len}
  localparam int unsigned RHS_LEN_LSB = 0;

  function automatic int unsigned lhs_base_lsb(input int unsigned addr_w, input int unsigned len_w);
    return addr_w + 2 * len_w;
  endfunction

  function automatic int unsigned lhs_len_lsb(input int unsigned addr_w, input int unsigned len_w);
    return addr_w + len_w;
  endfunction

  function automatic int unsigned rhs_base_lsb(input int unsigned len_w);
    return len_w;
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Holds one packed character-memory word and presents its chars MSB-first.
module word_unpacker #(
  parameter int unsigned CHARS_PER_WORD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic                          advance,
  input  logic [8*CHARS_PER_WORD-1:0]   word_in,
  output logic [7:0]                    char_out,
  output logic                          last_char
);

  localparam int unsigned IDX_W = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS_PER_WORD - 1);

  logic [8*CHARS_PER_WORD-1:0] word_q;
  logic [IDX_W-1:0]            idx_q;

  // Shifting the word left keeps the current char in the top byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      word_q <= word_in;
      idx_q  <= '0;
    end else if (advance) begin
      word_q <= word_q << 8;
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  assign char_out  = word_q[8*CHARS_PER_WORD-1 -: 8];
  assign last_char = (idx_q == LAST_IDX);

endmodule

// File: rtl/latex_stream_engine.sv
// Fetches a line's pointer entry and streams its LHS/RHS text as bytes
// over a valid/ready handshake, with optional separator and a terminator.
module latex_stream_engine
  import latex_stream_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 51,
  parameter int unsigned LINE_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned LEN_W          = 6,
  parameter int unsigned CHARS_PER_WORD = 2,
  parameter logic [7:0]  SEP_CHAR       = ASCII_EQUALS,
  parameter logic [7:0]  TERM_CHAR      = ASCII_NEWLINE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [LINE_W-1:0]             line,
  input  logic [1:0]                    mode,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          ptr_rd,
  output logic [LINE_W-1:0]             ptr_addr,
  input  logic [2*(ADDR_W+LEN_W)-1:0]   ptr_data,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [8*CHARS_PER_WORD-1:0]   mem_dout,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);

  localparam int unsigned LB_LSB = lhs_base_lsb(ADDR_W, LEN_W);
  localparam int unsigned LL_LSB = lhs_len_lsb(ADDR_W, LEN_W);
  localparam int unsigned RB_LSB = rhs_base_lsb(LEN_W);
  localparam logic [LINE_W:0] LINE_LIMIT = (LINE_W + 1)'(NUM_LINES);

  state_e              state;
  mode_e               mode_q;
  logic                seg_idx;
  logic [ADDR_W-1:0]   lhs_base_q, rhs_base_q;
  logic [LEN_W-1:0]    lhs_len_q, rhs_len_q, remain_q;
  logic [7:0]          ctl_byte;
  logic                emit_sel;

  logic [ADDR_W-1:0]   pd_lhs_base, pd_rhs_base, seg_base;
  logic [LEN_W-1:0]    pd_lhs_len, pd_rhs_len, seg_len;
  logic                seg_rhs, sep_next, xfer;
  logic                unp_load, unp_advance, unp_last;
  logic [7:0]          unp_char;

  assign pd_lhs_base = ptr_data[LB_LSB +: ADDR_W];
  assign pd_lhs_len  = ptr_data[LL_LSB +: LEN_W];
  assign pd_rhs_base = ptr_data[RB_LSB +: ADDR_W];
  assign pd_rhs_len  = ptr_data[RHS_LEN_LSB +: LEN_W];

  // In PWAIT the entry is taken straight from ptr_data so the first
  // segment can start without an extra SEG_INIT cycle.
  always_comb begin
    case (mode_q)
      MODE_LHS:     seg_rhs = 1'b0;
      MODE_RHS:     seg_rhs = 1'b1;
      MODE_LHS_RHS: seg_rhs = seg_idx;
      default:      seg_rhs = !seg_idx;
    endcase
    if (state == S_PWAIT) begin
      seg_base = seg_rhs ? pd_rhs_base : pd_lhs_base;
      seg_len  = seg_rhs ? pd_rhs_len  : pd_lhs_len;
    end else begin
      seg_base = seg_rhs ? rhs_base_q : lhs_base_q;
      seg_len  = seg_rhs ? rhs_len_q  : lhs_len_q;
    end
    sep_next = mode_q[1] && !seg_idx;
  end

  assign xfer        = out_valid && out_ready;
  assign unp_load    = (state == S_MWAIT);
  assign unp_advance = (state == S_EMIT) && xfer && (remain_q != LEN_W'(1)) && !unp_last;
  assign out_data    = emit_sel ? unp_char : ctl_byte;

  word_unpacker #(.CHARS_PER_WORD(CHARS_PER_WORD)) u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (unp_load),
    .advance   (unp_advance),
    .word_in   (mem_dout),
    .char_out  (unp_char),
    .last_char (unp_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= MODE_LHS;
      seg_idx    <= 1'b0;
      lhs_base_q <= '0;
      lhs_len_q  <= '0;
      rhs_base_q <= '0;
      rhs_len_q  <= '0;
      remain_q   <= '0;
      ctl_byte   <= '0;
      emit_sel   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      ptr_rd     <= 1'b0;
      ptr_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_q  <= mode_e'(mode);
          seg_idx <= 1'b0;
          if ({1'b0, line} >= LINE_LIMIT) begin
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_FIN;
          end else begin
            busy     <= 1'b1;
            ptr_rd   <= 1'b1;
            ptr_addr <= line;
            state    <= S_PTR;
          end
        end
        S_PTR: begin
          ptr_rd <= 1'b0;
          state  <= S_PWAIT;
        end
        S_PWAIT, S_SEG_INIT: begin
          if (state == S_PWAIT) begin
            lhs_base_q <= pd_lhs_base;
            lhs_len_q  <= pd_lhs_len;
            rhs_base_q <= pd_rhs_base;
            rhs_len_q  <= pd_rhs_len;
          end
          if (seg_len != '0) begin
            mem_addr <= seg_base;
            remain_q <= seg_len;
            mem_rd   <= 1'b1;
            state    <= S_FETCH;
          end else begin
            out_valid <= 1'b1;
            emit_sel  <= 1'b0;
            if (sep_next) begin
              ctl_byte <= SEP_CHAR;
              state    <= S_SEP;
            end else begin
              ctl_byte <= TERM_CHAR;
              out_last <= 1'b1;
              state    <= S_TERM;
            end
          end
        end
        S_FETCH: begin
          mem_rd <= 1'b0;
          state  <= S_MWAIT;
        end
        S_MWAIT: begin
          out_valid <= 1'b1;
          emit_sel  <= 1'b1;
          state     <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          remain_q <= remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            emit_sel <= 1'b0;
            if (sep_next) begin
              ctl_byte <= SEP_CHAR;
              state    <= S_SEP;
            end else begin
              ctl_byte <= TERM_CHAR;
              out_last <= 1'b1;
              state    <= S_TERM;
            end
          end else if (unp_last) begin
            out_valid <= 1'b0;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_rd    <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_SEP: if (out_ready) begin
          out_valid <= 1'b0;
          seg_idx   <= 1'b1;
          state     <= S_SEG_INIT;
        end
        S_TERM: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latex_stream_engine.sv
// Directed bench for latex_stream_engine with pointer-table and char-memory models.
module tb_latex_stream_engine;

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic [7:0]  line;
  logic [1:0]  mode;
  logic        busy, done, err, ptr_rd, mem_rd, out_valid, out_last;
  logic [7:0]  ptr_addr, mem_addr, out_data;
  logic [27:0] ptr_data;
  logic [15:0] mem_dout;

  always #5 clk = ~clk;

  latex_stream_engine #(
    .NUM_LINES(51), .LINE_W(8), .ADDR_W(8), .LEN_W(6), .CHARS_PER_WORD(2),
    .SEP_CHAR(8'h3D), .TERM_CHAR(8'h0A)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .line(line), .mode(mode),
    .busy(busy), .done(done), .err(err),
    .ptr_rd(ptr_rd), .ptr_addr(ptr_addr), .ptr_data(ptr_data),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  logic [27:0] ptab [256];
  logic [15:0] cmem [256];

  always @(posedge clk) begin
    if (ptr_rd) ptr_data <= ptab[ptr_addr];
    if (mem_rd) mem_dout <= cmem[mem_addr];
  end

  int tests = 0;
  int fails = 0;

  logic [63:0] got_bytes;
  logic [7:0]  got_last;
  logic [15:0] maddr_log;
  int          got_n, first_valid, done_cyc, last_xfer, hold_viol, n_mem_rd;
  logic        err_at_done, busy_at_start, busy_at_done;
  logic        ptr_rd_seen, mem_rd_seen, out_valid_seen;

  // Drives one request and records what the stream does until done (bounded).
  task automatic run_txn(input logic [7:0] ln, input logic [1:0] md, input int rmode, input bit hold_start);
    logic pv, pr, pl;
    logic [7:0] pd;
    got_bytes = '0; got_last = '0; maddr_log = '0;
    got_n = 0; first_valid = -1; done_cyc = -1; last_xfer = -1; hold_viol = 0; n_mem_rd = 0;
    err_at_done = 1'b0; busy_at_start = 1'b0; busy_at_done = 1'b0;
    ptr_rd_seen = 1'b0; mem_rd_seen = 1'b0; out_valid_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; line = ln; mode = md; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold_start) begin
      line = 8'hFF; mode = 2'd0;
    end else begin
      start = 1'b0;
    end
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (cyc == 0) busy_at_start = busy;
      if (ptr_rd) ptr_rd_seen = 1'b1;
      if (mem_rd) begin
        mem_rd_seen = 1'b1;
        maddr_log = {maddr_log[7:0], mem_addr};
        n_mem_rd++;
      end
      if (out_valid) out_valid_seen = 1'b1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (pv && !pr && (!out_valid || out_data !== pd || out_last !== pl)) hold_viol++;
      if (done) begin
        done_cyc = cyc; err_at_done = err; busy_at_done = busy; start = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_bytes = {got_bytes[55:0], out_data};
        got_last  = {got_last[6:0], out_last};
        got_n++;
        last_xfer = cyc;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; line = '0; mode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, err, ptr_rd, mem_rd, out_valid, out_last} !== 7'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected %b", {busy, done, err, ptr_rd, mem_rd, out_valid, out_last}, 7'b0);
    end
    tests++;
    if ({out_data, ptr_addr, mem_addr} !== 24'h0) begin
      fails++;
      $display("FAIL reset_buses: got %h expected %h", {out_data, ptr_addr, mem_addr}, 24'h0);
    end
  endtask

  task automatic test_lhs_sep_rhs();
    run_txn(8'd3, 2'd2, 0, 1'b0);
    tests++;
    if (got_bytes !== 64'h0000_313D_312F_730A || got_n != 6) begin
      fails++; $display("FAIL m2_stream: got %h (%0d bytes) expected 313d312f730a (6 bytes)", got_bytes, got_n);
    end
    tests++;
    if (got_last !== 8'b0000_0001) begin
      fails++; $display("FAIL m2_last: got %b expected %b", got_last, 8'b0000_0001);
    end
    tests++;
    if (first_valid != 4) begin
      fails++; $display("FAIL m2_latency: got %0d expected 4", first_valid);
    end
    tests++;
    if (done_cyc != 15 || done_cyc != last_xfer + 1) begin
      fails++; $display("FAIL m2_done: got cycle %0d (last byte %0d) expected 15", done_cyc, last_xfer);
    end
    tests++;
    if ({err_at_done, busy_at_start, busy_at_done} !== 3'b010) begin
      fails++; $display("FAIL m2_err_busy: got %b expected %b", {err_at_done, busy_at_start, busy_at_done}, 3'b010);
    end
  endtask

  task automatic test_rhs_sep_lhs();
    run_txn(8'd3, 2'd3, 0, 1'b1);
    tests++;
    if (got_bytes !== 64'h0000_312F_733D_310A || got_n != 6) begin
      fails++; $display("FAIL m3_stream: got %h (%0d bytes) expected 312f733d310a (6 bytes)", got_bytes, got_n);
    end
    tests++;
    if (got_last !== 8'b0000_0001 || err_at_done !== 1'b0 || done_cyc < 0) begin
      fails++; $display("FAIL m3_last_err: got last %b err %b done %0d expected 00000001 0 >=0", got_last, err_at_done, done_cyc);
    end
  endtask

  task automatic test_ready_toggle();
    run_txn(8'd3, 2'd1, 1, 1'b0);
    tests++;
    if (got_bytes !== 64'h0000_0000_312F_730A || got_n != 4) begin
      fails++; $display("FAIL m1_stream: got %h (%0d bytes) expected 312f730a (4 bytes)", got_bytes, got_n);
    end
    tests++;
    if (hold_viol != 0) begin
      fails++; $display("FAIL m1_hold: got %0d unstable stalls expected 0", hold_viol);
    end
    tests++;
    if (got_last !== 8'b0000_0001 || done_cyc != last_xfer + 1) begin
      fails++; $display("FAIL m1_last_done: got last %b done %0d expected 00000001 %0d", got_last, done_cyc, last_xfer + 1);
    end
  endtask

  task automatic test_range_error();
    logic [7:0] bad [2];
    bad[0] = 8'd51; bad[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      run_txn(bad[i], 2'd2, 0, 1'b0);
      tests++;
      if (done_cyc != 0 || err_at_done !== 1'b1) begin
        fails++; $display("FAIL range_err line %0d: got done %0d err %b expected 0 1", bad[i], done_cyc, err_at_done);
      end
      tests++;
      if ({ptr_rd_seen, mem_rd_seen, out_valid_seen, busy_at_done} !== 4'b0 || got_n != 0) begin
        fails++; $display("FAIL range_quiet line %0d: got %b/%0d expected 0000/0", bad[i],
                          {ptr_rd_seen, mem_rd_seen, out_valid_seen, busy_at_done}, got_n);
      end
    end
    run_txn(8'd50, 2'd2, 0, 1'b0);
    tests++;
    if (got_bytes !== 64'h3D0A || got_n != 2 || err_at_done !== 1'b0 || mem_rd_seen !== 1'b0) begin
      fails++; $display("FAIL line50_empty: got %h (%0d) err %b memrd %b expected 3d0a (2) 0 0",
                        got_bytes, got_n, err_at_done, mem_rd_seen);
    end
  endtask

  task automatic test_addr_wrap();
    run_txn(8'd7, 2'd2, 0, 1'b0);
    tests++;
    if (got_bytes !== 64'h0000_3D61_6263_640A || got_n != 6) begin
      fails++; $display("FAIL wrap_stream: got %h (%0d bytes) expected 3d616263640a (6 bytes)", got_bytes, got_n);
    end
    tests++;
    if (maddr_log !== 16'hFF00 || n_mem_rd != 2) begin
      fails++; $display("FAIL wrap_addr: got %h (%0d reads) expected ff00 (2 reads)", maddr_log, n_mem_rd);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int done_pulses;
    @(negedge clk);
    start = 1'b1; line = 8'd3; mode = 2'd1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h2F) begin
      fails++; $display("FAIL abort_stall: got valid %b data %h expected 1 2f", out_valid, out_data);
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tests++;
    if ({out_valid, busy} !== 2'b00) begin
      fails++; $display("FAIL abort_state: got valid/busy %b expected 00", {out_valid, busy});
    end
    done_pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_pulses++;
      @(posedge clk); @(negedge clk);
    end
    tests++;
    if (done_pulses != 0) begin
      fails++; $display("FAIL abort_done: got %0d done pulses expected 0", done_pulses);
    end
    run_txn(8'd3, 2'd0, 0, 1'b0);
    tests++;
    if (got_bytes !== 64'h310A || got_n != 2 || got_last !== 8'b01 || err_at_done !== 1'b0) begin
      fails++; $display("FAIL abort_restart: got %h (%0d) last %b err %b expected 310a (2) 01 0",
                        got_bytes, got_n, got_last, err_at_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ptab[i] = '0;
      cmem[i] = '0;
    end
    ptab[3]    = {8'h10, 6'd1, 8'h20, 6'd3};
    ptab[7]    = {8'h00, 6'd0, 8'hFF, 6'd4};
    cmem[8'h10] = 16'h3100;
    cmem[8'h20] = 16'h312F;
    cmem[8'h21] = 16'h7300;
    cmem[8'hFF] = 16'h6162;
    cmem[8'h00] = 16'h6364;

    test_reset();
    test_lhs_sep_rhs();
    test_rhs_sep_lhs();
    test_ready_toggle();
    test_range_error();
    test_addr_wrap();
    test_reset_abort();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
